fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Fetches program words, hands them to a CPU and paces execution.
//  Revision : 1.0
// ============================================================================
module fetch_sequencer #(
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] HALT_WORD = 16'hE000,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic              cpu_w,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);

    localparam int c_cyc_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // Last EXEC cycle index before the timeout; leaving on this edge means
    // exactly TIMEOUT cycles were spent in EXEC.
    localparam logic [c_cyc_w-1:0] c_tmo_last = c_cyc_w'(TIMEOUT - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_latch = 3'd2;
    localparam logic [2:0] c_st_issue = 3'd3;
    localparam logic [2:0] c_st_exec  = 3'd4;
    localparam logic [2:0] c_st_halt  = 3'd5;
    localparam logic [2:0] c_st_error = 3'd6;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [15:0]        r_count;
    logic [c_cyc_w-1:0] r_cyc;
    logic               r_seen_low;
    logic [15:0]        r_cpu_in;

    logic w_is_halt;
    logic w_done;
    logic w_timeout;
    logic w_idle_like;

    assign w_is_halt   = (mem_rdata == HALT_WORD);
    assign w_timeout   = (r_cyc == c_tmo_last);
    assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_halt) ||
                         (r_state == c_st_error);

    // A high cpu_w completes once a low has been seen; a CPU that never drops
    // cpu_w counts as finished on the second EXEC cycle (r_cyc == 1 implies
    // the first cycle was high whenever r_seen_low is still clear).
    assign w_done = cpu_w && (r_seen_low || (r_cyc == c_cyc_w'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_pc       <= '0;
            r_count    <= '0;
            r_cyc      <= '0;
            r_seen_low <= 1'b0;
            r_cpu_in   <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_halt, c_st_error: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_count <= '0;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    r_state <= c_st_latch;
                end
                c_st_latch: begin
                    if (w_is_halt) begin
                        r_state <= c_st_halt;
                    end else begin
                        r_cpu_in <= mem_rdata;
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_cyc      <= '0;
                    r_seen_low <= 1'b0;
                    r_state    <= c_st_exec;
                end
                c_st_exec: begin
                    r_cyc <= r_cyc + c_cyc_w'(1);
                    if (!cpu_w) begin
                        r_seen_low <= 1'b1;
                    end
                    if (w_done) begin
                        r_pc    <= r_pc + ADDR_W'(1);
                        if (r_count != 16'hFFFF) begin
                            r_count <= r_count + 16'd1;
                        end
                        r_state <= c_st_fetch;
                    end else if (w_timeout) begin
                        r_state <= c_st_error;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // The word is forwarded combinationally while latching so the CPU loads
    // it in the same cycle; afterwards the captured copy is held.
    assign cpu_load    = (r_state == c_st_latch) && !w_is_halt;
    assign cpu_in      = cpu_load ? mem_rdata : r_cpu_in;
    assign cpu_s       = (r_state == c_st_issue);
    assign mem_addr    = r_pc;
    assign busy        = !w_idle_like;
    assign halted      = (r_state == c_st_halt);
    assign error       = (r_state == c_st_error);
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_sequencer
//  Purpose  : Randomised lock-step check of fetch_sequencer against an
//             instruction-level timing model.
//  Revision : 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int          c_addr_w  = 2;
    localparam int          c_timeout = 255;
    localparam logic [15:0] c_halt    = 16'hE000;

    // Output flag patterns: {busy, halted, error, cpu_load, cpu_s}
    localparam logic [4:0] c_f_idle  = 5'b00000;
    localparam logic [4:0] c_f_busy  = 5'b10000;
    localparam logic [4:0] c_f_halt  = 5'b01000;
    localparam logic [4:0] c_f_err   = 5'b00100;
    localparam logic [4:0] c_f_load  = 5'b10010;
    localparam logic [4:0] c_f_issue = 5'b10001;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [c_addr_w-1:0] mem_addr;
    logic [15:0]         mem_rdata = 16'h0;
    logic [15:0]         cpu_in;
    logic                cpu_load;
    logic                cpu_s;
    logic                cpu_w;
    logic                busy;
    logic                halted;
    logic                error;
    logic [15:0]         instr_count;

    fetch_sequencer #(
        .ADDR_W (c_addr_w)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .cpu_s       (cpu_s),
        .cpu_w       (cpu_w),
        .busy        (busy),
        .halted      (halted),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory
    logic [15:0] mem [4];
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    // CPU model: after a start request, cpu_w stays low for next_delay cycles
    int next_delay = 0;
    int low_left   = 0;
    always @(posedge clk) begin
        if (cpu_s)             low_left <= next_delay;
        else if (low_left > 0) low_left <= low_left - 1;
    end
    assign cpu_w = (low_left == 0);

    logic [38:0] obs;
    assign obs = {mem_addr, busy, halted, error, cpu_load, cpu_s, cpu_in, instr_count};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_pc    = 0;
    int          m_cnt   = 0;
    logic [15:0] m_last  = 16'h0;
    logic [4:0]  m_flags = c_f_idle;

    task automatic check(input string tag, input logic [38:0] o, input logic [38:0] e);
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, o, e, $time);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [4:0] flags, input logic [15:0] cin);
        logic [1:0]  a;
        logic [15:0] c;
        a = m_pc[1:0];
        c = m_cnt[15:0];
        @(negedge clk);
        check(tag, obs, {a, flags, cin, c});
    endtask

    function automatic logic [15:0] nonhalt();
        logic [15:0] w;
        do w = 16'($urandom); while (w == c_halt);
        return w;
    endfunction

    task automatic reset_to_idle();
        reset  = 1'b0;
        start  = 1'b1;
        m_pc   = 0;
        m_cnt  = 0;
        m_last = 16'h0;
        expect_cycle("reset", c_f_idle, m_last);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) expect_cycle("idle_after_reset", c_f_idle, m_last);
        m_flags = c_f_idle;
    endtask

    // Walks a run from the start edge, predicting every cycle from the
    // per-instruction timing rules; start is randomised while busy.
    task automatic model_run(input int max_instr, input int rst_instr,
                             input int d_lo, input int d_hi, input int p_forever);
        int          d, c, n, rk, lim;
        logic [15:0] w;
        m_pc  = 0;
        m_cnt = 0;
        n     = 0;
        forever begin
            expect_cycle("fetch", c_f_busy, m_last);
            start = 1'($urandom_range(1, 0));
            w = mem[m_pc];
            if (w == c_halt) begin
                expect_cycle("latch_halt", c_f_busy, m_last);
                start = 1'b0;
                expect_cycle("halt", c_f_halt, m_last);
                m_flags = c_f_halt;
                return;
            end
            expect_cycle("latch", c_f_load, w);
            m_last = w;
            start  = 1'($urandom_range(1, 0));
            d = ($urandom_range(99, 0) < p_forever) ? 1000 : $urandom_range(d_hi, d_lo);
            next_delay = d;
            expect_cycle("issue", c_f_issue, m_last);
            start = 1'($urandom_range(1, 0));
            c   = (d == 0) ? 1 : d;
            lim = (c <= c_timeout - 1) ? c : c_timeout - 1;
            rk  = $urandom_range(lim, 0);
            for (int k = 0; k <= lim; k++) begin
                expect_cycle("exec", c_f_busy, m_last);
                if (n == rst_instr && k == rk) begin
                    reset_to_idle();
                    return;
                end
                start = 1'($urandom_range(1, 0));
            end
            if (c > c_timeout - 1) begin
                expect_cycle("error", c_f_err, m_last);
                m_flags = c_f_err;
                return;
            end
            m_pc = (m_pc + 1) % 4;
            if (m_cnt != 65535) m_cnt++;
            n++;
            if (n == max_instr) begin
                expect_cycle("fetch_cap", c_f_busy, m_last);
                reset_to_idle();
                return;
            end
        end
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) begin
            start = 1'b0;
            expect_cycle("hold", m_flags, m_last);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 16'h0;
        repeat (2) expect_cycle("reset_state", c_f_idle, m_last);
        reset = 1'b1;
        expect_cycle("idle", c_f_idle, m_last);

        // Basic program: two instructions then halt at pc=2, count=2
        mem = '{16'hD105, 16'hD203, 16'hE000, 16'h1234};
        start = 1'b1;
        model_run(100, -1, 3, 3, 0);
        hold(2);

        // Restart from HALT with a CPU that never drops cpu_w
        start = 1'b1;
        model_run(100, -1, 0, 0, 0);
        hold(1);

        // CPU stalls forever: ERROR after TIMEOUT EXEC cycles
        mem[0] = nonhalt();
        start = 1'b1;
        model_run(100, -1, 0, 0, 100);
        hold(2);

        // Address wrap: five completions through a 4-word space
        for (int i = 0; i < 4; i++) mem[i] = nonhalt();
        start = 1'b1;
        model_run(5, -1, 0, 4, 0);

        // Reset during EXEC of the second instruction
        start = 1'b1;
        model_run(100, 1, 0, 5, 0);

        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 4; i++)
                mem[i] = ($urandom_range(3, 0) == 0) ? c_halt : nonhalt();
            start = 1'b1;
            model_run(8, ($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : -1, 0, 6, 5);
            hold($urandom_range(2, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
